// File: rtl/ecall_unit_pkg.sv
// Shared CPU package: syscall codes and the ecall FSM state encoding.
package ecall_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DISPATCH     = 3'd1,
    ST_WAIT_PRESS   = 3'd2,
    ST_WAIT_RELEASE = 3'd3,
    ST_DONE         = 3'd4,
    ST_HALT         = 3'd5
  } ecall_state_e;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_READ_INT   = 32'd5;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  // True for codes that wait for the operator to press and release confirm.
  function automatic logic needs_confirm(input logic [31:0] code);
    return (code == SYS_PRINT_INT) || (code == SYS_PRINT_CHAR) ||
           (code == SYS_READ_INT);
  endfunction

endpackage

// File: rtl/ecall_unit_btn_debounce.sv
// Confirm-button conditioning: 2-flop synchronizer followed by a debouncer
// that accepts a new level only after DEBOUNCE_CYCLES consecutive samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so the counter never exceeds CNT_MAX.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer and debounce state; reset restarts the whole filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/ecall_unit.sv
// Environment-call unit: services print/read/exit syscalls using a
// 7-segment display, LEDs, switches and a debounced confirm button.
module ecall_unit
  import ecall_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Ecall,
  input  logic                Flush,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0,
  input  logic                btn_confirm,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                EcallDone,
  output logic                RegWriteA0,
  output logic [31:0]         WriteDataA0,
  output logic [31:0]         seg_value,
  output logic                seg_en,
  output logic [SW_WIDTH-1:0] led,
  output logic                halted
);

  ecall_state_e        state_q, state_d;
  logic                btn_level_s, btn_rise_s;
  logic [31:0]         code_q, code_d, arg_q, arg_d;
  logic [SW_WIDTH-1:0] sw_sync1_q, sw_sync2_q;
  logic [SW_WIDTH-1:0] sw_cap_q, sw_cap_d, led_q, led_d;
  logic [31:0]         seg_value_q, seg_value_d, wdata_q, wdata_d;
  logic                seg_en_q, seg_en_d, done_q, done_d;
  logic                rw_q, rw_d, halted_q, halted_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_confirm),
    .level_o(btn_level_s),
    .rise_o (btn_rise_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; Flush aborts everything except the absorbing HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Ecall && !Flush) state_d = ST_DISPATCH;
        else                 state_d = ST_IDLE;
      end
      ST_DISPATCH: begin
        if (needs_confirm(code_q))   state_d = ST_WAIT_PRESS;
        else if (code_q == SYS_EXIT) state_d = ST_HALT;
        else                         state_d = ST_DONE;
      end
      ST_WAIT_PRESS: begin
        if (btn_rise_s) state_d = ST_WAIT_RELEASE;
        else            state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_RELEASE: begin
        if (!btn_level_s) state_d = ST_DONE;
        else              state_d = ST_WAIT_RELEASE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (Flush && (state_q != ST_HALT)) begin
      state_d = ST_IDLE;
    end
  end

  // Output/datapath next values, keyed on the transition being taken so a
  // flushed transition never updates the display, LEDs or captured switches.
  always_comb begin
    code_d      = code_q;
    arg_d       = arg_q;
    sw_cap_d    = sw_cap_q;
    seg_value_d = seg_value_q;
    seg_en_d    = seg_en_q;
    led_d       = led_q;
    if ((state_q == ST_IDLE) && (state_d == ST_DISPATCH)) begin
      code_d = a7;
      arg_d  = a0;
    end else if ((state_q == ST_DISPATCH) && (state_d == ST_WAIT_PRESS)) begin
      if (code_q == SYS_PRINT_INT) begin
        seg_value_d = arg_q;
        seg_en_d    = 1'b1;
      end else if (code_q == SYS_PRINT_CHAR) begin
        led_d = SW_WIDTH'(arg_q[7:0]);
      end else begin
        led_d = led_q;
      end
    end else if ((state_q == ST_WAIT_PRESS) && (state_d == ST_WAIT_RELEASE)) begin
      if (code_q == SYS_READ_INT) sw_cap_d = sw_sync2_q;
      else                        sw_cap_d = sw_cap_q;
    end else begin
      code_d = code_q;
    end
    done_d   = (state_d == ST_DONE);
    rw_d     = done_d && (code_q == SYS_READ_INT);
    wdata_d  = rw_d ? 32'(sw_cap_q) : 32'd0;
    halted_d = (state_d == ST_HALT);
  end

  // Registered outputs, captured syscall operands and switch synchronizer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q      <= 32'd0;
      arg_q       <= 32'd0;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
      sw_cap_q    <= '0;
      seg_value_q <= 32'd0;
      seg_en_q    <= 1'b0;
      led_q       <= '0;
      done_q      <= 1'b0;
      rw_q        <= 1'b0;
      wdata_q     <= 32'd0;
      halted_q    <= 1'b0;
    end else begin
      code_q      <= code_d;
      arg_q       <= arg_d;
      sw_sync1_q  <= sw;
      sw_sync2_q  <= sw_sync1_q;
      sw_cap_q    <= sw_cap_d;
      seg_value_q <= seg_value_d;
      seg_en_q    <= seg_en_d;
      led_q       <= led_d;
      done_q      <= done_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      halted_q    <= halted_d;
    end
  end

  assign EcallDone   = done_q;
  assign RegWriteA0  = rw_q;
  assign WriteDataA0 = wdata_q;
  assign seg_value   = seg_value_q;
  assign seg_en      = seg_en_q;
  assign led         = led_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_ecall_unit.sv
// Self-checking bench for ecall_unit with a short debounce window.
module tb_ecall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Ecall = 1'b0, Flush = 1'b0, btn_confirm = 1'b0;
  logic [31:0] a7 = 32'd0, a0 = 32'd0;
  logic [15:0] sw = 16'd0;
  logic        EcallDone, RegWriteA0, seg_en, halted;
  logic [31:0] WriteDataA0, seg_value;
  logic [15:0] led;

  int total = 0;
  int bad   = 0;
  int p_cnt, rw_cnt;
  logic [31:0] wd_seen;

  ecall_unit #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .Ecall(Ecall), .Flush(Flush), .a7(a7), .a0(a0),
    .btn_confirm(btn_confirm), .sw(sw), .EcallDone(EcallDone),
    .RegWriteA0(RegWriteA0), .WriteDataA0(WriteDataA0),
    .seg_value(seg_value), .seg_en(seg_en), .led(led), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a7;
    logic [31:0] a0;
    logic [15:0] sw;
    bit          press;
    logic [31:0] seg;
    bit          seg_en;
    logic [15:0] led;
    bit          rw;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick n cycles, counting completion and write-back pulses.
  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (EcallDone === 1'b1) begin
        p_cnt++;
        wd_seen = WriteDataA0;
      end
      if (RegWriteA0 === 1'b1) rw_cnt++;
    end
  endtask

  // Full press (6 cycles) and release, watching for completion.
  task automatic press_release(input int release_budget);
    btn_confirm = 1'b1;
    watch(6);
    btn_confirm = 1'b0;
    watch(release_budget);
  endtask

  task automatic accept(input logic [31:0] code, input logic [31:0] arg);
    a7 = code;
    a0 = arg;
    Ecall = 1'b1;
    tick();
    Ecall = 1'b0;
  endtask

  // Unknown code: completion pulse exactly in the 2nd cycle after acceptance.
  task automatic run_unknown(input logic [31:0] code, input string tag);
    accept(code, 32'd0);
    check({tag, "_c1_done"}, {31'd0, EcallDone}, 32'd0);
    tick();
    check({tag, "_c2_done"}, {31'd0, EcallDone}, 32'd1);
    check({tag, "_c2_rw"}, {31'd0, RegWriteA0}, 32'd0);
    tick();
    check({tag, "_c3_done"}, {31'd0, EcallDone}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'd99, 32'h55, 16'h0, 1'b0, 32'd0, 1'b0, 16'h0, 1'b0, 32'd0};
    vecs[1] = '{32'd0, 32'h1, 16'h0, 1'b0, 32'd0, 1'b0, 16'h0, 1'b0, 32'd0};
    vecs[2] = '{32'd1, 32'h12345678, 16'h0, 1'b1, 32'h12345678, 1'b1, 16'h0, 1'b0, 32'd0};
    vecs[3] = '{32'd11, 32'hABCDEF41, 16'h0, 1'b1, 32'h12345678, 1'b1, 16'h0041, 1'b0, 32'd0};
    vecs[4] = '{32'd5, 32'h0, 16'h00A5, 1'b1, 32'h12345678, 1'b1, 16'h0041, 1'b1, 32'h000000A5};
    vecs[5] = '{32'd5, 32'h0, 16'hFFFF, 1'b1, 32'h12345678, 1'b1, 16'h0041, 1'b1, 32'h0000FFFF};
    vecs[6] = '{32'h80000005, 32'h0, 16'h0, 1'b0, 32'h12345678, 1'b1, 16'h0041, 1'b0, 32'd0};

    // Reset state.
    #12;
    check("rst_done", {31'd0, EcallDone}, 32'd0);
    check("rst_rw", {31'd0, RegWriteA0}, 32'd0);
    check("rst_wd", WriteDataA0, 32'd0);
    check("rst_seg", seg_value, 32'd0);
    check("rst_segen", {31'd0, seg_en}, 32'd0);
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_halt", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Table-driven syscalls.
    for (int i = 0; i < 7; i++) begin
      sw = vecs[i].sw;
      repeat (3) tick();
      accept(vecs[i].a7, vecs[i].a0);
      check($sformatf("v%0d_c1_done", i), {31'd0, EcallDone}, 32'd0);
      tick();
      check($sformatf("v%0d_seg", i), seg_value, vecs[i].seg);
      check($sformatf("v%0d_segen", i), {31'd0, seg_en}, {31'd0, vecs[i].seg_en});
      check($sformatf("v%0d_led", i), {16'd0, led}, {16'd0, vecs[i].led});
      if (!vecs[i].press) begin
        check($sformatf("v%0d_lat2_done", i), {31'd0, EcallDone}, 32'd1);
        check($sformatf("v%0d_rw", i), {31'd0, RegWriteA0}, 32'd0);
        tick();
        check($sformatf("v%0d_single", i), {31'd0, EcallDone}, 32'd0);
      end else begin
        check($sformatf("v%0d_wait_done", i), {31'd0, EcallDone}, 32'd0);
        p_cnt = 0; rw_cnt = 0; wd_seen = 32'd0;
        press_release(20);
        check($sformatf("v%0d_pulses", i), p_cnt, 32'd1);
        check($sformatf("v%0d_rw_pulses", i), rw_cnt, {31'd0, vecs[i].rw});
        if (vecs[i].rw) check($sformatf("v%0d_wd", i), wd_seen, vecs[i].wd);
      end
      repeat (2) tick();
    end

    // Bounce shorter than the debounce window must not advance WAIT_PRESS.
    accept(32'd1, 32'd7);
    tick();
    p_cnt = 0; rw_cnt = 0;
    btn_confirm = 1'b1; watch(1);
    btn_confirm = 1'b0; watch(1);
    btn_confirm = 1'b1; watch(1);
    btn_confirm = 1'b0; watch(1);
    btn_confirm = 1'b1; watch(3);
    btn_confirm = 1'b0; watch(12);
    check("bounce_no_done", p_cnt, 32'd0);
    press_release(20);
    check("bounce_then_press", p_cnt, 32'd1);
    repeat (2) tick();

    // Flush in WAIT_PRESS aborts; the unit is back in IDLE immediately.
    sw = 16'h1234;
    accept(32'd5, 32'd0);
    tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_no_done", {31'd0, EcallDone}, 32'd0);
    run_unknown(32'd99, "flush_idle");
    p_cnt = 0; rw_cnt = 0;
    press_release(20);
    check("flush_late_press", p_cnt, 32'd0);
    check("flush_late_rw", rw_cnt, 32'd0);

    // Flush in the DONE cycle: pulse still present.
    accept(32'd99, 32'd0);
    tick();
    Flush = 1'b1;
    check("flush_done_pulse", {31'd0, EcallDone}, 32'd1);
    tick();
    Flush = 1'b0;
    check("flush_done_after", {31'd0, EcallDone}, 32'd0);
    run_unknown(32'd77, "flush_done_idle");

    // Reset mid-press: the held button must be re-qualified from scratch.
    accept(32'd1, 32'h1111);
    tick();
    btn_confirm = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check("arst_seg", seg_value, 32'd0);
    check("arst_segen", {31'd0, seg_en}, 32'd0);
    check("arst_led", {16'd0, led}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    accept(32'd1, 32'h2222);
    tick();
    tick();
    btn_confirm = 1'b0;
    p_cnt = 0; rw_cnt = 0;
    watch(20);
    check("arst_held_ignored", p_cnt, 32'd0);
    press_release(20);
    check("arst_press_ok", p_cnt, 32'd1);

    // Exit halts; Ecall/Flush ignored; async reset releases.
    accept(32'd10, 32'd0);
    check("halt_c1", {31'd0, halted}, 32'd0);
    tick();
    check("halt_c2", {31'd0, halted}, 32'd1);
    a7 = 32'd99; Ecall = 1'b1; Flush = 1'b1;
    p_cnt = 0; rw_cnt = 0;
    watch(8);
    Ecall = 1'b0; Flush = 1'b0;
    check("halt_no_done", p_cnt, 32'd0);
    check("halt_stays", {31'd0, halted}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check("halt_arst", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_unknown(32'd42, "post_halt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ecall_unit.md
ECALL_UNIT -- requirements
Module: ecall_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000, cycles the confirm button must read stable before a level change is accepted.
REQ-002 SHALL have parameter SW_WIDTH, default 16, width of the switch input and LED output.
REQ-003 Ports (clock and reset first):
 clk  in  1  single system clock; all state on posedge
 rst  in  1  reset, asynchronous, active-low
 Ecall  in  1  system call request level from the controller
 Flush  in  1  branch/flush; aborts any syscall in progress
 a7  in  32  syscall code register value
 a0  in  32  syscall argument register value
 btn_confirm  in  1  raw, asynchronous confirm push-button
 sw  in  SW_WIDTH  raw switch inputs
 EcallDone  out  1  one-cycle completion pulse to the controller
 RegWriteA0  out  1  write-back enable for register a0
 WriteDataA0  out  32  write-back data for a0
 seg_value  out  32  value shown on the 7-segment display
 seg_en  out  1  display enable
 led  out  SW_WIDTH  LED outputs
 halted  out  1  program has executed exit

Function
REQ-004 FSM states: IDLE, DISPATCH, WAIT_PRESS, WAIT_RELEASE, DONE, HALT.
REQ-005 IDLE: Ecall=1 and Flush=0 -> DISPATCH; a7 and a0 captured into internal registers on that edge.
REQ-006 DISPATCH by captured code: 1 (print int) -> seg_value=a0, seg_en=1, go WAIT_PRESS; 11 (print char) -> led low 8 bits = a0[7:0], upper bits 0, go WAIT_PRESS; 5 (read int) -> WAIT_PRESS; 10 (exit) -> HALT; any other code -> DONE.
REQ-007 WAIT_PRESS: debounced confirm rising edge -> WAIT_RELEASE; for code 5, sw captured on that edge.
REQ-008 WAIT_RELEASE: debounced confirm low -> DONE; prevents a single press completing two syscalls.
REQ-009 DONE: EcallDone=1 for exactly one cycle; next state IDLE unconditionally.
REQ-010 DONE with code 5: RegWriteA0=1 in the same cycle, WriteDataA0 = captured sw zero-extended to 32 bits; otherwise RegWriteA0=0.
REQ-011 EcallDone, RegWriteA0 SHALL be registered (driven from state), never combinational from inputs.
REQ-012 Latency: unknown code -> EcallDone in the 2nd cycle after the IDLE acceptance edge (IDLE->DISPATCH->DONE).
REQ-013 Flush=1 in any state except HALT -> IDLE next edge; no EcallDone, no write-back; seg_value/led retain last value.
REQ-014 Flush and DONE in the same cycle: DONE pulse still emitted (already registered); next state IDLE.
REQ-015 HALT: absorbing until reset; halted=1; Ecall and Flush ignored; EcallDone never asserted.
REQ-016 Ecall dropping while in WAIT_PRESS/WAIT_RELEASE without Flush SHALL NOT abort the syscall.
REQ-017 btn_confirm SHALL pass a 2-flop synchronizer, then a debouncer: output changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples; counter saturates, no wrap.
REQ-018 sw SHALL be 2-flop synchronized before capture.

Reset
REQ-019 rst=0 asynchronously forces IDLE, all outputs 0, captured registers 0, debouncer output 0, debounce counter 0.
REQ-020 rst deassertion mid-press: debouncer restarts; a button already held SHALL require DEBOUNCE_CYCLES stable cycles before recognition.

Structure
REQ-021 Syscall code constants (1, 5, 10, 11) and the state enum SHALL live in the shared CPU package.
REQ-022 Debounce logic SHALL be a sub-module btn_debounce (synchronizer + counter), parameterized by DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4 on bench)
REQ-023 a7=99, Ecall pulse -> EcallDone high exactly 2 cycles after acceptance edge, RegWriteA0=0.
REQ-024 a7=5, sw=0x00A5, press 6 cycles, release 6 cycles -> RegWriteA0=1, WriteDataA0=0x000000A5 with EcallDone, one pulse only.
REQ-025 a7=1, a0=0x12345678 -> seg_value=0x12345678, seg_en=1 before press; EcallDone only after press+release.
REQ-026 a7=5, Flush asserted in WAIT_PRESS -> IDLE next cycle, no EcallDone, later press produces nothing.
REQ-027 Button bounce 1010 pattern shorter than 4 cycles in WAIT_PRESS -> no state change.
REQ-028 a7=10 -> halted=1, further Ecall ignored; rst=0 -> IDLE, halted=0 asynchronously.
